// File: rtl/mii_64b66b_encoder.sv
// mii_64b66b_encoder
//   64b/66b transmit encoder. Each valid cycle one 64-bit MII word and its
//   8-bit control mask are classified (C, S, D, T_k or E). The class and the
//   transmit state pick the 66-bit block to emit. Illegal sequences are
//   replaced by an error block. A saturating counter records how many error
//   blocks have been sent.
//
// Ports
//   clk         rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_valid     input word valid this cycle
//   i_tx_data   MII data, lane i = [8i+7:8i], lane 0 transmitted first
//   i_tx_ctrl   bit i marks lane i as a control character
//   o_valid     o_tx_block valid (one cycle after the accepted word)
//   o_tx_block  [1:0] sync header, [65:2] payload
//   o_err_cnt   error blocks emitted, saturating at all-ones
//   o_state     current transmit state (debug observation only)
//
// Handshake: a word is consumed on every rising edge where i_valid=1. There
// is no ready signal and no backpressure. o_valid is asserted for exactly one
// cycle per consumed word, one cycle after that edge.
module mii_64b66b_encoder #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_tx_data,
  input  logic [CTRL_WIDTH-1:0]    i_tx_ctrl,
  output logic                     o_valid,
  output logic [DATA_WIDTH+1:0]    o_tx_block,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic [2:0]               o_state
);

  localparam logic [2:0] TX_INIT = 3'd0;
  localparam logic [2:0] TX_C    = 3'd1;
  localparam logic [2:0] TX_D    = 3'd2;
  localparam logic [2:0] TX_T    = 3'd3;
  localparam logic [2:0] TX_E    = 3'd4;

  localparam logic [2:0] CLS_C = 3'd0;
  localparam logic [2:0] CLS_S = 3'd1;
  localparam logic [2:0] CLS_D = 3'd2;
  localparam logic [2:0] CLS_T = 3'd3;
  localparam logic [2:0] CLS_E = 3'd4;

  localparam logic [7:0] CH_I = 8'h07;
  localparam logic [7:0] CH_E = 8'hFE;
  localparam logic [7:0] CH_S = 8'hFB;
  localparam logic [7:0] CH_T = 8'hFD;
  localparam logic [6:0] CODE_E = 7'h1E;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [65:0] ERR_BLOCK = {{8{CODE_E}}, 8'h1E, SYNC_CTRL};

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic [2:0]  cls;
  logic        emit_err;
  logic [65:0] blk;

  // C-word check: every lane must be control and either /I/ or /E/.
  // /I/ maps to code 0, so only /E/ lanes need writing into c_codes.
  logic        c_ok;
  logic [55:0] c_codes;
  logic [7:0]  c_lane;

  always_comb begin
    c_ok    = 1'b1;
    c_codes = '0;
    c_lane  = '0;
    for (int i = 0; i < 8; i++) begin
      c_lane = i_tx_data[8*i +: 8];
      if (!i_tx_ctrl[i]) begin
        c_ok = 1'b0;
      end else if (c_lane == CH_E) begin
        c_codes[7*i +: 7] = CODE_E;
      end else if (c_lane != CH_I) begin
        c_ok = 1'b0;
      end
    end
  end

  // Terminate detection. Lane k must be the first control lane, hold /T/,
  // and every later lane must be control /I/. At most one k can match.
  logic       t_hit;
  logic       t_ok;
  logic [2:0] t_lane;

  always_comb begin
    t_hit  = 1'b0;
    t_ok   = 1'b0;
    t_lane = '0;
    for (int k = 0; k < 8; k++) begin
      t_ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (j < k) begin
          if (i_tx_ctrl[j]) t_ok = 1'b0;
        end else if (j == k) begin
          if (!i_tx_ctrl[j] || i_tx_data[8*j +: 8] != CH_T) t_ok = 1'b0;
        end else begin
          if (!i_tx_ctrl[j] || i_tx_data[8*j +: 8] != CH_I) t_ok = 1'b0;
        end
      end
      if (t_ok) begin
        t_hit  = 1'b1;
        t_lane = 3'(k);
      end
    end
  end

  // Terminate payload: data lanes below the /T/ lane, everything else zero.
  // Lane 7 can never be data in a T block, so 56 bits suffice.
  logic [55:0] t_data;
  logic [7:0]  t_type;

  always_comb begin
    t_data = '0;
    for (int j = 0; j < 7; j++) begin
      if (3'(j) < t_lane) t_data[8*j +: 8] = i_tx_data[8*j +: 8];
    end
  end

  always_comb begin
    case (t_lane)
      3'd0:    t_type = 8'h87;
      3'd1:    t_type = 8'h99;
      3'd2:    t_type = 8'hAA;
      3'd3:    t_type = 8'hB4;
      3'd4:    t_type = 8'hCC;
      3'd5:    t_type = 8'hD2;
      3'd6:    t_type = 8'hE1;
      default: t_type = 8'hFF;
    endcase
  end

  always_comb begin
    cls = CLS_E;
    if (i_tx_ctrl == 8'hFF && c_ok) begin
      cls = CLS_C;
    end else if (i_tx_ctrl == 8'h01 && i_tx_data[7:0] == CH_S) begin
      cls = CLS_S;
    end else if (i_tx_ctrl == 8'h00) begin
      cls = CLS_D;
    end else if (t_hit) begin
      cls = CLS_T;
    end
  end

  // Sequencing rules. Anything not explicitly legal for the current state
  // becomes an error block and parks the machine in TX_E.
  always_comb begin
    nxt_state = TX_E;
    emit_err  = 1'b1;
    case (state)
      TX_D: begin
        if (cls == CLS_D) begin
          nxt_state = TX_D;
          emit_err  = 1'b0;
        end else if (cls == CLS_T) begin
          nxt_state = TX_T;
          emit_err  = 1'b0;
        end
      end
      TX_E: begin
        if (cls == CLS_C) begin
          nxt_state = TX_C;
          emit_err  = 1'b0;
        end else if (cls == CLS_D) begin
          nxt_state = TX_D;
          emit_err  = 1'b0;
        end else if (cls == CLS_T) begin
          nxt_state = TX_T;
          emit_err  = 1'b0;
        end
      end
      default: begin
        if (cls == CLS_C) begin
          nxt_state = TX_C;
          emit_err  = 1'b0;
        end else if (cls == CLS_S) begin
          nxt_state = TX_D;
          emit_err  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    blk = ERR_BLOCK;
    if (!emit_err) begin
      case (cls)
        CLS_C:   blk = {c_codes, 8'h1E, SYNC_CTRL};
        CLS_S:   blk = {i_tx_data[63:8], 8'h78, SYNC_CTRL};
        CLS_D:   blk = {i_tx_data, SYNC_DATA};
        CLS_T:   blk = {t_data, t_type, SYNC_CTRL};
        default: blk = ERR_BLOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= TX_INIT;
      o_valid    <= 1'b0;
      o_tx_block <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        state      <= nxt_state;
        o_tx_block <= blk;
        if (emit_err && o_err_cnt != '1) begin
          o_err_cnt <= o_err_cnt + 1'b1;
        end
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_mii_64b66b_encoder.sv
module tb_mii_64b66b_encoder;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_C    = 3'd1;
  localparam logic [2:0] S_D    = 3'd2;
  localparam logic [2:0] S_T    = 3'd3;
  localparam logic [2:0] S_E    = 3'd4;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [65:0] IDLE_B  = 66'h079;
  localparam logic [65:0] ERR_B   = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [65:0] START_B = {56'hD5555555555555, 8'h78, 2'b01};
  localparam logic [63:0] DATA_W  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [65:0] DATA_B  = {64'hAAAAAAAAAAAAAAAA, 2'b10};

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [63:0] i_tx_data;
  logic [7:0]  i_tx_ctrl;
  logic        o_valid;
  logic [65:0] o_tx_block;
  logic [15:0] o_err_cnt;
  logic [2:0]  o_state;
  logic        s_valid;
  logic [65:0] s_tx_block;
  logic [1:0]  s_err_cnt;
  logic [2:0]  s_state;

  int checks;
  int failures;

  mii_64b66b_encoder u_dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_tx_data(i_tx_data), .i_tx_ctrl(i_tx_ctrl),
    .o_valid(o_valid), .o_tx_block(o_tx_block),
    .o_err_cnt(o_err_cnt), .o_state(o_state)
  );

  mii_64b66b_encoder #(.ERR_CNT_WIDTH(2)) u_sat (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_tx_data(i_tx_data), .i_tx_ctrl(i_tx_ctrl),
    .o_valid(s_valid), .o_tx_block(s_tx_block),
    .o_err_cnt(s_err_cnt), .o_state(s_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // drivers: inputs change on the falling edge, outputs sampled 1 ns after
  // the rising edge that consumed the word
  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    i_valid   = 1'b1;
    i_tx_data = d;
    i_tx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_gap();
    @(negedge clk);
    i_valid   = 1'b0;
    i_tx_data = 64'(0);
    i_tx_ctrl = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_tx_block !== 66'h0) begin failures++; $display("FAIL reset_block got=%h exp=0", o_tx_block); end
    checks++; if (o_err_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_err_cnt); end
    checks++; if (o_state !== S_INIT) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", o_state, S_INIT); end
  endtask

  task automatic test_idle();
    // latency: the word is set up but no edge has consumed it yet
    @(negedge clk);
    i_valid = 1'b1; i_tx_data = IDLE_W; i_tx_ctrl = 8'hFF;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL idle_latency got=%0b exp=0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_tx_block !== IDLE_B || o_valid !== 1'b1) begin failures++; $display("FAIL idle_0 got=%h v=%0b exp=%h", o_tx_block, o_valid, IDLE_B); end
    for (int i = 1; i < 3; i++) begin
      drive_word(IDLE_W, 8'hFF);
      checks++; if (o_tx_block !== IDLE_B || o_valid !== 1'b1) begin failures++; $display("FAIL idle_%0d got=%h exp=%h", i, o_tx_block, IDLE_B); end
    end
    checks++; if (o_state !== S_C) begin failures++; $display("FAIL idle_state got=%0d exp=%0d", o_state, S_C); end
    checks++; if (o_err_cnt !== 16'd0) begin failures++; $display("FAIL idle_cnt got=%0d exp=0", o_err_cnt); end
  endtask

  task automatic test_start_data();
    drive_word(START_W, 8'h01);
    checks++; if (o_tx_block !== START_B) begin failures++; $display("FAIL start_block got=%h exp=%h", o_tx_block, START_B); end
    checks++; if (o_state !== S_D) begin failures++; $display("FAIL start_state got=%0d exp=%0d", o_state, S_D); end
    drive_word(DATA_W, 8'h00);
    checks++; if (o_tx_block !== DATA_B || o_valid !== 1'b1) begin failures++; $display("FAIL data_block got=%h exp=%h", o_tx_block, DATA_B); end
  endtask

  task automatic test_terminate();
    logic [65:0] exp_b;
    exp_b = {24'h0, 32'hAAAAAAAA, 8'hCC, 2'b01};
    drive_word(64'h070707FDAAAAAAAA, 8'hF0);
    checks++; if (o_tx_block !== exp_b) begin failures++; $display("FAIL term4_block got=%h exp=%h", o_tx_block, exp_b); end
    checks++; if (o_state !== S_T) begin failures++; $display("FAIL term4_state got=%0d exp=%0d", o_state, S_T); end
    drive_word(IDLE_W, 8'hFF);
    checks++; if (o_tx_block !== IDLE_B) begin failures++; $display("FAIL term_idle got=%h exp=%h", o_tx_block, IDLE_B); end
  endtask

  task automatic test_seq_error();
    logic [65:0] exp_b;
    drive_word(DATA_W, 8'h00);
    checks++; if (o_tx_block !== ERR_B) begin failures++; $display("FAIL seqerr_block got=%h exp=%h", o_tx_block, ERR_B); end
    checks++; if (o_err_cnt !== 16'd1) begin failures++; $display("FAIL seqerr_cnt got=%0d exp=1", o_err_cnt); end
    checks++; if (o_state !== S_E) begin failures++; $display("FAIL seqerr_state got=%0d exp=%0d", o_state, S_E); end
    exp_b = {56'h0, 8'h87, 2'b01};
    drive_word(64'h07070707070707FD, 8'hFF);
    checks++; if (o_tx_block !== exp_b) begin failures++; $display("FAIL term0_block got=%h exp=%h", o_tx_block, exp_b); end
    checks++; if (o_state !== S_T || o_err_cnt !== 16'd1) begin failures++; $display("FAIL term0_state got=%0d/%0d exp=%0d/1", o_state, o_err_cnt, S_T); end
  endtask

  task automatic test_gap();
    logic [65:0] exp_b;
    drive_word(START_W, 8'h01);
    drive_word(DATA_W, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_gap();
      checks++; if (o_valid !== 1'b0 || o_tx_block !== DATA_B) begin failures++; $display("FAIL gap_hold_%0d got=%h v=%0b exp=%h v=0", i, o_tx_block, o_valid, DATA_B); end
    end
    checks++; if (o_state !== S_D || o_err_cnt !== 16'd1) begin failures++; $display("FAIL gap_state got=%0d/%0d exp=%0d/1", o_state, o_err_cnt, S_D); end
    drive_word(64'h0123456789ABCDEF, 8'h00);
    exp_b = {64'h0123456789ABCDEF, 2'b10};
    checks++; if (o_tx_block !== exp_b || o_valid !== 1'b1) begin failures++; $display("FAIL gap_resume got=%h exp=%h", o_tx_block, exp_b); end
    drive_word(64'hFD11223344556677, 8'h80);
    exp_b = {56'h11223344556677, 8'hFF, 2'b01};
    checks++; if (o_tx_block !== exp_b) begin failures++; $display("FAIL term7_block got=%h exp=%h", o_tx_block, exp_b); end
    checks++; if (o_err_cnt !== 16'd1) begin failures++; $display("FAIL term7_cnt got=%0d exp=1", o_err_cnt); end
  endtask

  task automatic test_c_variants();
    logic [65:0] exp_b;
    exp_b = {49'h0, 7'h1E, 8'h1E, 2'b01};
    drive_word(64'h07070707070707FE, 8'hFF);
    checks++; if (o_tx_block !== exp_b) begin failures++; $display("FAIL c_elane got=%h exp=%h", o_tx_block, exp_b); end
    checks++; if (o_state !== S_C) begin failures++; $display("FAIL c_elane_state got=%0d exp=%0d", o_state, S_C); end
    drive_word(64'h070707079C070707, 8'hFF);
    checks++; if (o_tx_block !== ERR_B || o_err_cnt !== 16'd2) begin failures++; $display("FAIL c_badchar got=%h cnt=%0d exp=%h cnt=2", o_tx_block, o_err_cnt, ERR_B); end
    drive_word(START_W, 8'h01);
    checks++; if (o_tx_block !== ERR_B || o_err_cnt !== 16'd3 || o_state !== S_E) begin failures++; $display("FAIL start_in_e got=%h cnt=%0d st=%0d exp=%h cnt=3 st=%0d", o_tx_block, o_err_cnt, o_state, ERR_B, S_E); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_word({$urandom, $urandom}, 8'h55);
      if (i == 1) begin
        checks++; if (s_err_cnt !== 2'd2) begin failures++; $display("FAIL sat_mid got=%0d exp=2", s_err_cnt); end
      end
    end
    checks++; if (s_err_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", s_err_cnt); end
    checks++; if (o_err_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=5", o_err_cnt); end
    checks++; if (s_tx_block !== ERR_B || s_state !== S_E) begin failures++; $display("FAIL sat_block got=%h st=%0d exp=%h st=%0d", s_tx_block, s_state, ERR_B, S_E); end
  endtask

  task automatic test_reset_midframe();
    drive_word(IDLE_W, 8'hFF);
    drive_word(START_W, 8'h01);
    drive_word(DATA_W, 8'h00);
    checks++; if (o_state !== S_D) begin failures++; $display("FAIL mid_pre_state got=%0d exp=%0d", o_state, S_D); end
    #2;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_tx_block !== 66'h0) begin failures++; $display("FAIL mid_rst_out got=%h v=%0b exp=0 v=0", o_tx_block, o_valid); end
    checks++; if (o_err_cnt !== 16'd0 || o_state !== S_INIT) begin failures++; $display("FAIL mid_rst_state got=%0d/%0d exp=0/%0d", o_err_cnt, o_state, S_INIT); end
    @(negedge clk);
    i_rst_n = 1'b1;
    drive_word(DATA_W, 8'h00);
    checks++; if (o_tx_block !== ERR_B || o_err_cnt !== 16'd1) begin failures++; $display("FAIL mid_post_d got=%h cnt=%0d exp=%h cnt=1", o_tx_block, o_err_cnt, ERR_B); end
    drive_gap();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    i_rst_n   = 1'b1;
    i_valid   = 1'b0;
    i_tx_data = 64'(0);
    i_tx_ctrl = 8'h00;
    test_reset();
    test_idle();
    test_start_data();
    test_terminate();
    test_seq_error();
    test_gap();
    test_c_variants();
    test_saturation();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
